// File: rtl/ahb_master_input_stage.sv
// AHB-Lite matrix master input stage: captures and replays an address phase the matrix
// could not accept. Optional hold timeout with a two-cycle ERROR enabled by AHB_INPUT_STAGE_TIMEOUT_EN.
module ahb_master_input_stage #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [ADDR_WIDTH-1:0] m_HADDR,
    input  logic [1:0]            m_HTRANS,
    input  logic                  m_HWRITE,
    input  logic [2:0]            m_HSIZE,
    input  logic [2:0]            m_HBURST,
    input  logic [3:0]            m_HPROT,
    input  logic [DATA_WIDTH-1:0] m_HWDATA,
    output logic                  m_HREADYOUT,
    output logic                  m_HRESP,
    output logic [DATA_WIDTH-1:0] m_HRDATA,
    output logic [ADDR_WIDTH-1:0] mx_HADDR,
    output logic [1:0]            mx_HTRANS,
    output logic                  mx_HWRITE,
    output logic [2:0]            mx_HSIZE,
    output logic [2:0]            mx_HBURST,
    output logic [3:0]            mx_HPROT,
    output logic [DATA_WIDTH-1:0] mx_HWDATA,
    output logic                  mx_REQ,
    input  logic                  mx_GRANT,
    input  logic                  mx_HREADY,
    input  logic                  mx_HRESP,
    input  logic [DATA_WIDTH-1:0] mx_HRDATA
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] haddr;
        logic [1:0]            htrans;
        logic                  hwrite;
        logic [2:0]            hsize;
        logic [2:0]            hburst;
        logic [3:0]            hprot;
    } ap_t;

`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_HOLD = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 256) ? 16 : 8;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_HOLD = 2'd2
    } state_e;
`endif

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    state_e state_q;
    state_e state_d;
    ap_t    hold_q;
    ap_t    hold_d;
    ap_t    live_s;
    ap_t    fwd_s;
    logic   ready_s;
    logic   resp_s;
    logic   live_valid_s;
    logic   req_s;
    logic   accept_s;

    function automatic state_e sample_next(input logic lv, input logic acc);
        if (lv && acc) begin
            return ST_DATA;
        end else if (lv) begin
            return ST_HOLD;
        end else begin
            return ST_IDLE;
        end
    endfunction

    assign live_s       = '{haddr: m_HADDR, htrans: m_HTRANS, hwrite: m_HWRITE,
                            hsize: m_HSIZE, hburst: m_HBURST, hprot: m_HPROT};
    assign live_valid_s = m_HTRANS[1] & ready_s;
    assign req_s        = (state_q == ST_HOLD) | live_valid_s;
    assign accept_s     = req_s & mx_GRANT & mx_HREADY;

    // Master-side response and the address phase presented to the matrix, per state.
    always_comb begin
        ready_s = 1'b1;
        resp_s  = 1'b0;
        fwd_s   = live_s;
        case (state_q)
            ST_IDLE: begin
                ready_s = 1'b1;
                resp_s  = 1'b0;
                fwd_s   = live_s;
            end
            ST_DATA: begin
                ready_s = mx_HREADY;
                resp_s  = mx_HRESP;
                fwd_s   = live_s;
                // The master is not sampled while the slave stalls, so nothing is offered.
                if (!mx_HREADY) begin
                    fwd_s.htrans = 2'b00;
                end else begin
                    fwd_s.htrans = live_s.htrans;
                end
            end
            ST_HOLD: begin
                ready_s = 1'b0;
                resp_s  = 1'b0;
                fwd_s   = hold_q;
            end
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
            ST_ERR1: begin
                ready_s      = 1'b0;
                resp_s       = 1'b1;
                fwd_s        = live_s;
                fwd_s.htrans = 2'b00;
            end
            ST_ERR2: begin
                ready_s = 1'b1;
                resp_s  = 1'b1;
                fwd_s   = live_s;
            end
`endif
            default: begin
                ready_s      = 1'b1;
                resp_s       = 1'b0;
                fwd_s        = live_s;
                fwd_s.htrans = 2'b00;
            end
        endcase
    end

    // Next state, hold-register capture/release and hold wait counter.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (ready_s) begin
                    state_d = sample_next(live_valid_s, accept_s);
                    if (live_valid_s && !accept_s) begin
                        hold_d = live_s;
                    end else begin
                        hold_d = hold_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    state_d = ST_DATA;
                    hold_d  = '0;
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
                end else if (cnt_q == CNT_LIM) begin
                    state_d = ST_ERR1;
                    hold_d  = '0;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = ST_HOLD;
                end
`endif
            end
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                state_d = sample_next(live_valid_s, accept_s);
                if (live_valid_s && !accept_s) begin
                    hold_d = live_s;
                end else begin
                    hold_d = hold_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, hold register and counter flops with synchronous active-low reset.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m_HREADYOUT = ready_s;
    assign m_HRESP     = resp_s;
    assign m_HRDATA    = mx_HRDATA;
    assign mx_HADDR    = fwd_s.haddr;
    assign mx_HTRANS   = fwd_s.htrans;
    assign mx_HWRITE   = fwd_s.hwrite;
    assign mx_HSIZE    = fwd_s.hsize;
    assign mx_HBURST   = fwd_s.hburst;
    assign mx_HPROT    = fwd_s.hprot;
    assign mx_HWDATA   = m_HWDATA;
    assign mx_REQ      = req_s;

endmodule

// File: tb/tb_ahb_master_input_stage.sv
// Bench for ahb_master_input_stage: directed scenarios plus random traffic checked against
// a transaction-level model (pending-address queue, outstanding data phase, error phase).
module tb_ahb_master_input_stage;

`ifdef AHB_INPUT_STAGE_TIMEOUT_EN
    localparam int  TB_TO  = 4;
    localparam bit  TO_EN  = 1'b1;
`else
    localparam int  TB_TO  = 256;
    localparam bit  TO_EN  = 1'b0;
`endif

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] m_HADDR;
    logic [1:0]  m_HTRANS;
    logic        m_HWRITE;
    logic [2:0]  m_HSIZE;
    logic [2:0]  m_HBURST;
    logic [3:0]  m_HPROT;
    logic [31:0] m_HWDATA;
    logic        m_HREADYOUT;
    logic        m_HRESP;
    logic [31:0] m_HRDATA;
    logic [31:0] mx_HADDR;
    logic [1:0]  mx_HTRANS;
    logic        mx_HWRITE;
    logic [2:0]  mx_HSIZE;
    logic [2:0]  mx_HBURST;
    logic [3:0]  mx_HPROT;
    logic [31:0] mx_HWDATA;
    logic        mx_REQ;
    logic        mx_GRANT;
    logic        mx_HREADY;
    logic        mx_HRESP;
    logic [31:0] mx_HRDATA;

    int checks = 0;
    int errors = 0;

    // Model state: address phases waiting for the matrix, outstanding data phase, error phase.
    logic [44:0] pend_q[$];
    bit          outst;
    int          err_ph;
    int          hcnt;

    ahb_master_input_stage #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_HADDR(m_HADDR), .m_HTRANS(m_HTRANS), .m_HWRITE(m_HWRITE), .m_HSIZE(m_HSIZE),
        .m_HBURST(m_HBURST), .m_HPROT(m_HPROT), .m_HWDATA(m_HWDATA),
        .m_HREADYOUT(m_HREADYOUT), .m_HRESP(m_HRESP), .m_HRDATA(m_HRDATA),
        .mx_HADDR(mx_HADDR), .mx_HTRANS(mx_HTRANS), .mx_HWRITE(mx_HWRITE), .mx_HSIZE(mx_HSIZE),
        .mx_HBURST(mx_HBURST), .mx_HPROT(mx_HPROT), .mx_HWDATA(mx_HWDATA), .mx_REQ(mx_REQ),
        .mx_GRANT(mx_GRANT), .mx_HREADY(mx_HREADY), .mx_HRESP(mx_HRESP), .mx_HRDATA(mx_HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, compare with the model, then advance the model to the next edge.
    task automatic step(input logic rst, input logic [31:0] addr, input logic [1:0] tr,
                        input logic wr, input logic [31:0] wdata, input logic grant,
                        input logic hrdy, input logic hresp, input logic [31:0] rdata);
        logic [44:0] live;
        logic [44:0] fwd;
        logic        e_rdy;
        logic        e_resp;
        logic        e_req;
        logic        acc;
        @(negedge HCLK);
        HRESETn   = rst;
        m_HADDR   = addr;
        m_HTRANS  = tr;
        m_HWRITE  = wr;
        m_HSIZE   = 3'($urandom_range(0, 7));
        m_HBURST  = 3'($urandom_range(0, 7));
        m_HPROT   = 4'($urandom_range(0, 15));
        m_HWDATA  = wdata;
        mx_GRANT  = grant;
        mx_HREADY = hrdy;
        mx_HRESP  = hresp;
        mx_HRDATA = rdata;
        #1;
        live = {addr, tr, wr, m_HSIZE, m_HBURST, m_HPROT};
        fwd  = live;
        if (err_ph == 1) begin
            e_rdy = 1'b0; e_resp = 1'b1; fwd[12:11] = 2'b00;
        end else if (err_ph == 2) begin
            e_rdy = 1'b1; e_resp = 1'b1;
        end else if (pend_q.size() != 0) begin
            e_rdy = 1'b0; e_resp = 1'b0; fwd = pend_q[0];
        end else if (outst) begin
            e_rdy = hrdy; e_resp = hresp;
            if (!hrdy) fwd[12:11] = 2'b00;
        end else begin
            e_rdy = 1'b1; e_resp = 1'b0;
        end
        e_req = (pend_q.size() != 0) || (tr[1] && e_rdy);
        chk("hreadyout", 64'(m_HREADYOUT), 64'(e_rdy));
        chk("hresp", 64'(m_HRESP), 64'(e_resp));
        chk("req", 64'(mx_REQ), 64'(e_req));
        chk("fwd_ap", 64'({mx_HADDR, mx_HTRANS, mx_HWRITE, mx_HSIZE, mx_HBURST, mx_HPROT}), 64'(fwd));
        chk("hwdata", 64'(mx_HWDATA), 64'(wdata));
        chk("hrdata", 64'(m_HRDATA), 64'(rdata));
        acc = e_req && grant && hrdy;
        if (!rst) begin
            pend_q.delete(); outst = 1'b0; err_ph = 0; hcnt = 0;
        end else if (err_ph == 1) begin
            err_ph = 2;
        end else if (pend_q.size() != 0) begin
            if (acc) begin
                void'(pend_q.pop_front()); outst = 1'b1;
            end else if (TO_EN && hcnt == TB_TO - 1) begin
                pend_q.delete(); err_ph = 1; outst = 1'b0;
            end else begin
                hcnt++;
            end
        end else if (e_rdy) begin
            err_ph = 0;
            outst  = tr[1] && acc;
            if (tr[1] && !acc) begin
                pend_q.push_back(live); hcnt = 0;
            end
        end
    endtask

    initial begin
        HRESETn = 1'b0; m_HADDR = '0; m_HTRANS = 2'b00; m_HWRITE = 1'b0; m_HSIZE = 3'd0;
        m_HBURST = 3'd0; m_HPROT = 4'd0; m_HWDATA = '0; mx_GRANT = 1'b0; mx_HREADY = 1'b1;
        mx_HRESP = 1'b0; mx_HRDATA = '0;
        outst = 1'b0; err_ph = 0; hcnt = 0;

        // Reset, then idle bus
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst_rdy", 64'(m_HREADYOUT), 64'd1);
        chk("rst_req", 64'(mx_REQ), 64'd0);
        chk("rst_trans", 64'(mx_HTRANS), 64'd0);

        // Single granted read to 0x1000
        step(1'b1, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("rd_req", 64'(mx_REQ), 64'd1);
        chk("rd_addr", 64'(mx_HADDR), 64'h1000);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        chk("rd_data", 64'(m_HRDATA), 64'hDEAD_BEEF);
        chk("rd_rdy", 64'(m_HREADYOUT), 64'd1);

        // Write to 0x2000 held while the master address moves on
        step(1'b1, 32'h0000_2000, 2'b10, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_2100 + 32'(i), 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("hold_addr", 64'(mx_HADDR), 64'h2000);
            chk("hold_rdy", 64'(m_HREADYOUT), 64'd0);
        end
        step(1'b1, 32'h0000_2100, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("hold_acc_req", 64'(mx_REQ), 64'd1);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h55AA_33CC, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("wr_wdata", 64'(mx_HWDATA), 64'h55AA_33CC);

        // Two wait states, then pipelined NONSEQ to 0x3000 not granted: DATA -> HOLD
        step(1'b1, 32'h0000_4000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h0000_3000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("ws_trans", 64'(mx_HTRANS), 64'd0);
        end
        step(1'b1, 32'h0000_3000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0000_3100, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("d2h_addr", 64'(mx_HADDR), 64'h3000);
        chk("d2h_req", 64'(mx_REQ), 64'd1);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Two-cycle slave ERROR; NONSEQ in the first error cycle is not forwarded
        step(1'b1, 32'h0000_5000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0000_6000, 2'b10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
        chk("err1_resp", 64'(m_HRESP), 64'd1);
        chk("err1_req", 64'(mx_REQ), 64'd0);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
        chk("err2_resp", 64'(m_HRESP), 64'd1);
        chk("err2_rdy", 64'(m_HREADYOUT), 64'd1);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset while holding
        step(1'b1, 32'h0000_7000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("hrst_req", 64'(mx_REQ), 64'd0);
        chk("hrst_rdy", 64'(m_HREADYOUT), 64'd1);

        if (TO_EN) begin
            // Grant withheld: four HOLD cycles, ERR1, ERR2, back to IDLE
            step(1'b1, 32'h0000_8000, 2'b10, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            for (int i = 0; i < 4; i++) begin
                step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
                chk("to_hold_rdy", 64'(m_HREADYOUT), 64'd0);
            end
            step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("to_err1", 64'({m_HREADYOUT, m_HRESP, mx_REQ}), 64'b010);
            step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("to_err2", 64'({m_HREADYOUT, m_HRESP}), 64'b11);
            step(1'b1, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
            chk("to_idle", 64'({m_HREADYOUT, m_HRESP}), 64'b10);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) != 0), $urandom(), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
